// File: rtl/quotient_bcd_conv.sv
// -----------------------------------------------------------------------------
// quotient_bcd_conv
//
// Purpose:
//    Sequential binary-to-BCD converter placed directly after the restoring
//    divider. It takes an N-bit unsigned quotient or remainder over a
//    valid/ready handshake. It converts the value with the shift-and-add-3
//    (double-dabble) algorithm, one input bit per clock. It then presents D
//    packed BCD digits on a valid/ready output for display or serial
//    reporting.
//
// Parameters:
//    N          binary input width in bits
//    D          number of BCD output digits; 10**D must exceed 2**N - 1.
//               Extra digits are zero-padded.
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_valid   bin_in carries a value to convert this cycle
//    in_ready   converter is idle and will take bin_in on this edge
//    bin_in     unsigned binary value to convert
//    out_valid  bcd_out holds a completed conversion
//    out_ready  consumer takes bcd_out on this edge
//    bcd_out    packed BCD result, units digit in bits [3:0]
//    busy       a conversion is being shifted through
// -----------------------------------------------------------------------------
module quotient_bcd_conv #(
   parameter int N = 8,
   parameter int D = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   bin_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*D-1:0] bcd_out,
   output logic           busy
);

   // Counter width is large enough to hold the value N itself.
   localparam int CW = $clog2(N + 1);
   localparam int BW = 4 * D;

   // The counter holds this value during the last shift step.
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   // Smallest power of ten above the requested digit count, used only to
   // reject parameter sets that cannot hold the largest input value.
   function automatic longint pow10(input int digits);
      longint acc;
      acc = 1;
      for (int k = 0; k < digits; k++) begin
         acc = acc * 10;
      end
      return acc;
   endfunction

   // Refuse to elaborate when D digits are too few for an N-bit value.
   // Otherwise the upper digits would silently lose carries.
   if (pow10(D) <= ((longint'(1) << N) - 1)) begin : g_digit_check
      $error("quotient_bcd_conv: D is too small for N");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q,     state_d;
   logic [N-1:0]    bin_work_q,  bin_work_d;
   logic [BW-1:0]   bcd_work_q,  bcd_work_d;
   logic [CW-1:0]   cnt_q,       cnt_d;
   logic [BW-1:0]   bcd_out_q,   bcd_out_d;
   logic            out_valid_q, out_valid_d;

   // Working BCD after the parallel add-3 correction of this step.
   logic [BW-1:0]   bcd_corr;
   // Working BCD after the correction and the one-bit left shift.
   logic [BW-1:0]   bcd_shifted;
   // High during the final shift step of a conversion.
   logic            last_step;

   // State register. Reset drops any in-flight conversion and returns to
   // IDLE, so the block is immediately ready for a fresh value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A capture in IDLE starts N shift steps. After the
   // step that brings the count to N, the result waits in DONE until the
   // consumer takes it. Nothing is accepted or queued in SHIFT or DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the registered state. in_ready depends only on
   // state, never on out_ready, because there is no skid buffer.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         SHIFT:   busy     = 1'b1;
         default: begin
            in_ready = 1'b0;
            busy     = 1'b0;
         end
      endcase
   end

   // Double-dabble correction. Any digit that is 5 or more gets 3 added, so
   // it carries correctly into the next digit after the doubling shift.
   // All digits are corrected in parallel from the pre-shift value. A digit
   // is at most 9 here, so the 4-bit add never wraps.
   always_comb begin
      bcd_corr = bcd_work_q;
      for (int i = 0; i < D; i++) begin
         if (bcd_work_q[4*i +: 4] >= 4'd5) begin
            bcd_corr[4*i +: 4] = bcd_work_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // The shift runs across the concatenation {bcd, bin}. The binary MSB
   // moves into the units digit of the BCD register.
   assign bcd_shifted = {bcd_corr[BW-2:0], bin_work_q[N-1]};
   assign last_step   = (cnt_q == LAST_STEP);

   // Datapath next-state logic. bcd_out is loaded only at the end of the
   // last shift step, so it holds the previous result through IDLE and
   // through the next conversion.
   always_comb begin
      bin_work_d  = bin_work_q;
      bcd_work_d  = bcd_work_q;
      cnt_d       = cnt_q;
      bcd_out_d   = bcd_out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_work_d = bin_in;
               bcd_work_d = '0;
               cnt_d      = '0;
            end
         end
         SHIFT: begin
            bcd_work_d = bcd_shifted;
            bin_work_d = bin_work_q << 1;
            cnt_d      = cnt_q + CW'(1);
            if (last_step) begin
               bcd_out_d   = bcd_shifted;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers. Reset clears everything, including the visible
   // result, so no residue from an aborted or earlier conversion remains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_work_q  <= '0;
         bcd_work_q  <= '0;
         cnt_q       <= '0;
         bcd_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         bin_work_q  <= bin_work_d;
         bcd_work_q  <= bcd_work_d;
         cnt_q       <= cnt_d;
         bcd_out_q   <= bcd_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bcd_out   = bcd_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_quotient_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_quotient_bcd_conv
//
// Purpose:
//    Scoreboard bench for quotient_bcd_conv with N=8 and D=3. The driver
//    pushes the decimal expectation of every accepted value. A separate
//    monitor pops and compares it whenever the converter hands a result
//    over. The monitor also tracks busy length, latency and output hold
//    under backpressure.
// -----------------------------------------------------------------------------
module tb_quotient_bcd_conv;

   localparam int N = 8;
   localparam int D = 3;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   bin_in;
   logic           out_valid;
   logic           out_ready;
   logic [4*D-1:0] bcd_out;
   logic           busy;

   typedef struct {
      logic [N-1:0] value;
      int           acceptEdge;
   } expItem_t;

   expItem_t       scb[$];
   int             cmpCount   = 0;
   int             failCount  = 0;
   int             cyc        = 0;
   int             lastAccept = 0;
   int             busyCount  = 0;
   bit             prevValid  = 1'b0;
   bit             prevReady  = 1'b0;
   bit             idleCheck  = 1'b0;
   logic [4*D-1:0] prevBcd    = '0;
   bit             randReady  = 1'b0;
   bit             readyLevel = 1'b1;

   quotient_bcd_conv #(.N(N), .D(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
      .busy      (busy)
   );

   // Free-running clock. Posedges fall at 5, 15, 25 and so on.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to timestamp acceptances and result arrival.
   always @(posedge clk) begin
      cyc = cyc + 1;
   end

   // Consumer ready, updated just after each rising edge. It is either a
   // fixed level chosen by the main sequence or a random stall pattern.
   initial out_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
   end

   // Reference: decimal digits of the value, by plain division.
   function automatic logic [4*D-1:0] toBcd(input int v);
      logic [4*D-1:0] r;
      int             rest;
      r    = '0;
      rest = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(rest % 10);
         rest        = rest / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      cmpCount = cmpCount + 1;
      if (actual !== expected) begin
         failCount = failCount + 1;
         $display("[TB] FAIL %s: got %0h, wanted %0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic reportFail(input string name);
      cmpCount  = cmpCount + 1;
      failCount = failCount + 1;
      $display("[TB] FAIL %s at cycle %0d", name, cyc);
   endtask

   // Offer a value until the converter takes it. The expectation is pushed
   // at the negedge before the accepting edge. Returns just after that edge.
   task automatic applyStimulus(input logic [N-1:0] v, input bit keepValid);
      int waited;
      in_valid = 1'b1;
      bin_in   = v;
      waited   = 0;
      forever begin
         @(negedge clk);
         if (in_ready && !rst) break;
         waited = waited + 1;
         if (waited > 200) begin
            reportFail("accept timeout");
            in_valid = 1'b0;
            return;
         end
      end
      scb.push_back('{value: v, acceptEdge: cyc + 1});
      lastAccept = cyc + 1;
      @(posedge clk);
      #1;
      if (!keepValid) in_valid = 1'b0;
   endtask

   // Wait until every pushed expectation is consumed and the output is idle.
   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n = n + 1;
      end while ((scb.size() != 0 || out_valid) && n < maxCycles);
      if (scb.size() != 0 || out_valid) reportFail("drain timeout");
      @(posedge clk);
      #1;
   endtask

   // Monitor. On each negedge it looks at what the next rising edge will
   // see. At a result handshake it pops and compares against the
   // scoreboard. It also checks busy length, latency and that the result
   // holds while stalled.
   always @(negedge clk) begin
      if (rst) begin
         busyCount = 0;
         prevValid = 1'b0;
         prevReady = 1'b0;
         idleCheck = 1'b0;
      end else begin
         if (idleCheck) begin
            checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
            idleCheck = 1'b0;
         end
         if (busy) busyCount = busyCount + 1;
         if (out_valid && !prevValid) begin
            checkOutput("busy cycles", busyCount, N);
            busyCount = 0;
            if (scb.size() == 0) reportFail("result with nothing pending");
            else checkOutput("latency", cyc - scb[0].acceptEdge, N);
         end
         if (out_valid) begin
            checkOutput("in_ready in DONE", 32'(in_ready), 32'd0);
         end
         if (out_valid && prevValid && !prevReady) begin
            checkOutput("bcd_out held in stall", 32'(bcd_out), 32'(prevBcd));
         end
         if (out_valid && out_ready) begin
            if (scb.size() == 0) begin
               reportFail("duplicate result");
            end else begin
               expItem_t e;
               e = scb.pop_front();
               checkOutput("bcd_out", 32'(bcd_out), 32'(toBcd(int'(e.value))));
            end
            idleCheck = 1'b1;
         end
         prevValid = out_valid;
         prevReady = out_ready;
         prevBcd   = bcd_out;
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence covering reset, directed values, backpressure,
   // back-to-back input, a mid-conversion reset and a stalled full sweep.
   initial begin
      int e1;
      logic [N-1:0] directed[5];
      directed = '{8'd255, 8'd99, 8'd100, 8'd9, 8'd10};
      rst      = 1'b1;
      in_valid = 1'b0;
      bin_in   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset bcd_out", 32'(bcd_out), 32'd0);

      $display("[TB] zero and directed values");
      applyStimulus(8'd0, 1'b0);
      waitDrain(50);
      foreach (directed[i]) begin
         applyStimulus(directed[i], 1'b0);
         waitDrain(50);
      end

      $display("[TB] backpressure");
      readyLevel = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(8'd173, 1'b0);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n = n + 1;
         end
         if (!out_valid) reportFail("173 never completed");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      bin_in   = 8'd42;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall out_valid", 32'(out_valid), 32'd1);
         checkOutput("stall bcd_out", 32'(bcd_out), 32'h173);
         checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      readyLevel = 1'b1;
      waitDrain(50);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("42 not captured", 32'(busy), 32'd0);

      $display("[TB] back-to-back");
      applyStimulus(8'd37, 1'b1);
      e1 = lastAccept;
      applyStimulus(8'd200, 1'b0);
      checkOutput("accept spacing", lastAccept - e1, N + 2);
      waitDrain(50);

      $display("[TB] reset mid-conversion");
      applyStimulus(8'd200, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
      checkOutput("async rst busy", 32'(busy), 32'd0);
      checkOutput("async rst bcd_out", 32'(bcd_out), 32'd0);
      checkOutput("async rst in_ready", 32'(in_ready), 32'd1);
      scb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(8'd58, 1'b0);
      waitDrain(50);

      $display("[TB] sweep with random stalls");
      randReady = 1'b1;
      for (int v = 0; v < 256; v++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         applyStimulus(8'(v), (v != 255) && ($urandom_range(0, 1) == 1));
      end
      in_valid = 1'b0;
      waitDrain(400);
      randReady = 1'b0;

      checkOutput("scoreboard empty", scb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmpCount, failCount);
      $finish;
   end

endmodule
